// File: rtl/fetch_queue.sv
// Y86-64 fetch stage: decodes one instruction per cycle from a combinational
// instruction port, predicts the next PC and queues decoded entries for decode.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          MEM_SIZE = 1024,
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [63:0]              imem_addr,
  input  logic [79:0]              imem_rdata,
  input  logic                     redirect_valid,
  input  logic [63:0]              redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               out_icode,
  output logic [3:0]               out_ifun,
  output logic [3:0]               out_rA,
  output logic [3:0]               out_rB,
  output logic [63:0]              out_valC,
  output logic [63:0]              out_valP,
  output logic [63:0]              out_pc,
  output logic [2:0]               out_stat,
  output logic [$clog2(DEPTH):0]   q_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);
  localparam logic [64:0]   MEM_LIM = 65'(MEM_SIZE);
  localparam logic [2:0] ST_AOK = 3'd1, ST_HLT = 3'd2, ST_ADR = 3'd3, ST_INS = 3'd4;

  typedef enum logic [1:0] {S_RUN, S_WAIT_RET, S_STOPPED} state_e;

  typedef struct packed {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valC;
    logic [63:0] valP;
    logic [63:0] pc;
    logic [2:0]  stat;
  } entry_t;

  state_e          state_q, state_d;
  logic [63:0]     pc_q, pc_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  entry_t          fifo_q [DEPTH];

  entry_t      dec;
  entry_t      head;
  logic [3:0]  len;
  logic        has_reg, has_valC_long, has_valC_short, is_adr, is_ins;
  logic [63:0] next_pc;
  logic        push, pop;

  // Field decode, status classification and next-PC prediction
  always_comb begin
    dec            = '0;
    dec.icode      = imem_rdata[7:4];
    dec.ifun       = imem_rdata[3:0];
    dec.pc         = pc_q;
    len            = 4'd1;
    has_reg        = 1'b0;
    has_valC_long  = 1'b0;
    has_valC_short = 1'b0;
    case (dec.icode)
      4'h2, 4'h6, 4'hA, 4'hB: begin len = 4'd2;  has_reg = 1'b1; end
      4'h7, 4'h8:             begin len = 4'd9;  has_valC_short = 1'b1; end
      4'h3, 4'h4, 4'h5:       begin len = 4'd10; has_reg = 1'b1; has_valC_long = 1'b1; end
      default:                len = 4'd1;
    endcase
    dec.rA   = has_reg ? imem_rdata[15:12] : 4'hF;
    dec.rB   = has_reg ? imem_rdata[11:8]  : 4'hF;
    dec.valC = has_valC_long  ? imem_rdata[79:16] :
               has_valC_short ? imem_rdata[71:8]  : 64'd0;
    // The 65-bit sum keeps PC wrap-around visible to the bounds check.
    is_adr = ({1'b0, pc_q} >= MEM_LIM) || (({1'b0, pc_q} + {61'd0, len}) > MEM_LIM);
    is_ins = (dec.icode > 4'hB)
          || (!(dec.icode inside {4'h2, 4'h6, 4'h7}) && (dec.ifun != 4'h0))
          || ((dec.icode == 4'h2 || dec.icode == 4'h7) && (dec.ifun > 4'h6))
          || ((dec.icode == 4'h6) && (dec.ifun > 4'h3));
    if (is_adr)                  dec.stat = ST_ADR;
    else if (is_ins)             dec.stat = ST_INS;
    else if (dec.icode == 4'h0)  dec.stat = ST_HLT;
    else                         dec.stat = ST_AOK;
    dec.valP = pc_q + ((dec.stat == ST_INS) ? 64'd1 : {60'd0, len});
    next_pc  = (dec.icode == 4'h7 || dec.icode == 4'h8) ? dec.valC : dec.valP;
  end

  assign push = (state_q == S_RUN) && (count_q < FULL) && !redirect_valid;
  assign pop  = out_valid && out_ready && !redirect_valid;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect_valid) begin
      state_d  = S_RUN;
      pc_d     = redirect_pc;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
        if (dec.stat != ST_AOK)     state_d = S_STOPPED;
        else if (dec.icode == 4'h9) state_d = S_WAIT_RET;
        else                        pc_d    = next_pc;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_RUN;
      pc_q     <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Queue storage is data only; occupancy gating hides stale slots.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= dec;
  end

  assign imem_addr = pc_q;
  assign q_count   = count_q;
  assign out_valid = (count_q != '0);
  assign head      = out_valid ? fifo_q[rd_ptr_q] : '0;
  assign out_icode = head.icode;
  assign out_ifun  = head.ifun;
  assign out_rA    = head.rA;
  assign out_rB    = head.rB;
  assign out_valC  = head.valC;
  assign out_valP  = head.valP;
  assign out_pc    = head.pc;
  assign out_stat  = head.stat;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a default-size instance for sequencing and a
// MEM_SIZE=16 instance for the address/illegal-instruction stops.
module tb_fetch_queue;
  logic        clk = 1'b0;
  logic        rst, rst_e;
  logic [7:0]  mem [256];

  logic [63:0] addr, redir_pc, addr_e, redir_pc_e;
  logic [79:0] rdata, rdata_e;
  logic        redir, ready, valid, redir_e, ready_e, valid_e;
  logic [3:0]  icode, ifun, rA, rB, icode_e, ifun_e, rA_e, rB_e;
  logic [63:0] valC, valP, pc, valC_e, valP_e, pc_e;
  logic [2:0]  stat, stat_e;
  logic [2:0]  cnt, cnt_e;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [79:0] fetch_bytes(input logic [63:0] a);
    logic [79:0] r;
    logic [63:0] b;
    r = '0;
    for (int i = 0; i < 10; i++) begin
      b = a + 64'(i);
      if (b < 64'd256) r[8*i +: 8] = mem[b[7:0]];
    end
    return r;
  endfunction

  assign rdata   = fetch_bytes(addr);
  assign rdata_e = fetch_bytes(addr_e);

  fetch_queue #(.DEPTH(4), .MEM_SIZE(1024), .RESET_PC(64'd0)) u_dut (
    .clk(clk), .rst(rst), .imem_addr(addr), .imem_rdata(rdata),
    .redirect_valid(redir), .redirect_pc(redir_pc),
    .out_valid(valid), .out_ready(ready),
    .out_icode(icode), .out_ifun(ifun), .out_rA(rA), .out_rB(rB),
    .out_valC(valC), .out_valP(valP), .out_pc(pc), .out_stat(stat),
    .q_count(cnt)
  );

  fetch_queue #(.DEPTH(4), .MEM_SIZE(16), .RESET_PC(64'd0)) u_err (
    .clk(clk), .rst(rst_e), .imem_addr(addr_e), .imem_rdata(rdata_e),
    .redirect_valid(redir_e), .redirect_pc(redir_pc_e),
    .out_valid(valid_e), .out_ready(ready_e),
    .out_icode(icode_e), .out_ifun(ifun_e), .out_rA(rA_e), .out_rB(rB_e),
    .out_valC(valC_e), .out_valP(valP_e), .out_pc(pc_e), .out_stat(stat_e),
    .q_count(cnt_e)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic restart();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rst_e = 1'b1;
    redir = 1'b0; redir_pc = '0; redir_e = 1'b0; redir_pc_e = '0;
    ready = 1'b1; ready_e = 1'b1;
    clear_mem();

    // Sequential program: irmovq $10,%rdx ; nop ; halt
    mem[0] = 8'h30; mem[1] = 8'hF2; mem[2] = 8'h0A;
    mem[10] = 8'h10; mem[11] = 8'h00;
    tick();
    chk("rst_count", 64'(cnt), 64'd0);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_addr", addr, 64'd0);
    chk("rst_pc", pc, 64'd0);
    chk("rst_icode", 64'(icode), 64'd0);
    chk("rst_stat", 64'(stat), 64'd0);
    rst = 1'b0;
    tick();
    chk("seq0_valid", 64'(valid), 64'd1);
    chk("seq0_pc", pc, 64'd0);
    chk("seq0_icode", 64'(icode), 64'd3);
    chk("seq0_rA", 64'(rA), 64'hF);
    chk("seq0_rB", 64'(rB), 64'd2);
    chk("seq0_valC", valC, 64'd10);
    chk("seq0_valP", valP, 64'd10);
    chk("seq0_stat", 64'(stat), 64'd1);
    tick();
    chk("seq1_pc", pc, 64'd10);
    chk("seq1_icode", 64'(icode), 64'd1);
    chk("seq1_valP", valP, 64'd11);
    tick();
    chk("seq2_pc", pc, 64'd11);
    chk("seq2_stat", 64'(stat), 64'd2);
    tick(); tick(); tick();
    chk("seq_end_valid", 64'(valid), 64'd0);
    chk("seq_end_addr", addr, 64'd11);

    // Backpressure: eight nops then halt, decode stalled
    clear_mem();
    for (int i = 0; i < 8; i++) mem[i] = 8'h10;
    ready = 1'b0;
    restart();
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("bp_count%0d", i), 64'(cnt), 64'(i));
    end
    chk("bp_addr", addr, 64'd4);
    tick(); tick();
    chk("bp_hold_count", 64'(cnt), 64'd4);
    chk("bp_hold_addr", addr, 64'd4);
    ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("bp_drain_valid%0d", k), 64'(valid), 64'd1);
      chk($sformatf("bp_drain_pc%0d", k), pc, 64'(k));
      tick();
    end
    chk("bp_tail_pc", pc, 64'd8);
    // Asynchronous reset mid-stream clears the queue without waiting for an edge
    rst = 1'b1;
    #1;
    chk("async_rst_count", 64'(cnt), 64'd0);
    chk("async_rst_valid", 64'(valid), 64'd0);
    chk("async_rst_addr", addr, 64'd0);

    // Jump prediction: jmp 0x20 predicted taken
    clear_mem();
    mem[0] = 8'h70; mem[1] = 8'h20; mem[32] = 8'h10;
    restart();
    tick();
    chk("jmp_pc", pc, 64'd0);
    chk("jmp_valC", valC, 64'h20);
    chk("jmp_valP", valP, 64'd9);
    chk("jmp_addr", addr, 64'h20);
    tick();
    chk("jmp_target_pc", pc, 64'h20);

    // ret stalls fetch until a redirect
    clear_mem();
    mem[0] = 8'h90; mem[64] = 8'h10;
    restart();
    tick();
    chk("ret_icode", 64'(icode), 64'd9);
    chk("ret_stat", 64'(stat), 64'd1);
    for (int i = 0; i < 5; i++) tick();
    chk("ret_wait_valid", 64'(valid), 64'd0);
    chk("ret_wait_addr", addr, 64'd0);
    redir = 1'b1; redir_pc = 64'h40;
    tick();
    redir = 1'b0;
    chk("ret_redir_valid", 64'(valid), 64'd0);
    chk("ret_redir_addr", addr, 64'h40);
    tick();
    chk("ret_redir_pc", pc, 64'h40);

    // Flush while full
    clear_mem();
    for (int i = 0; i < 8; i++) mem[i] = 8'h10;
    mem[128] = 8'h10;
    ready = 1'b0;
    restart();
    for (int i = 0; i < 4; i++) tick();
    chk("flush_full", 64'(cnt), 64'd4);
    redir = 1'b1; redir_pc = 64'h80;
    tick();
    redir = 1'b0;
    chk("flush_count", 64'(cnt), 64'd0);
    chk("flush_valid", 64'(valid), 64'd0);
    tick();
    chk("flush_head_pc", pc, 64'h80);
    chk("flush_head_count", 64'(cnt), 64'd1);

    // Error stops on the MEM_SIZE=16 instance
    rst = 1'b1;
    clear_mem();
    mem[0] = 8'hC0;
    mem[2] = 8'h64; mem[3] = 8'h12;
    mem[8] = 8'h30; mem[9] = 8'hF2; mem[10] = 8'h0A;
    tick();
    rst_e = 1'b0;
    tick();
    chk("ins_icode_pc", pc_e, 64'd0);
    chk("ins_icode_stat", 64'(stat_e), 64'd4);
    tick(); tick(); tick();
    chk("ins_icode_stop_valid", 64'(valid_e), 64'd0);
    chk("ins_icode_stop_addr", addr_e, 64'd0);
    redir_e = 1'b1; redir_pc_e = 64'd2;
    tick();
    redir_e = 1'b0;
    tick();
    chk("ins_ifun_pc", pc_e, 64'd2);
    chk("ins_ifun_stat", 64'(stat_e), 64'd4);
    chk("ins_ifun_valP", valP_e, 64'd3);
    tick(); tick(); tick();
    chk("ins_ifun_stop_valid", 64'(valid_e), 64'd0);
    chk("ins_ifun_stop_addr", addr_e, 64'd2);
    redir_e = 1'b1; redir_pc_e = 64'd8;
    tick();
    redir_e = 1'b0;
    tick();
    chk("adr_pc", pc_e, 64'd8);
    chk("adr_stat", 64'(stat_e), 64'd3);
    chk("adr_icode", 64'(icode_e), 64'd3);
    chk("adr_valC", valC_e, 64'd10);
    tick(); tick(); tick();
    chk("adr_stop_valid", 64'(valid_e), 64'd0);
    chk("adr_stop_addr", addr_e, 64'd8);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised Y86-64 fetch stage for the pipelined core. It reads instruction bytes from a combinational instruction-memory port and decodes the fixed-format fields. It predicts the next PC and pushes one decoded instruction per cycle into a DEPTH-entry FIFO that feeds decode through a valid/ready handshake. It adds redirect/flush, ret stalling, halt/error stopping and backpressure, none of which the single-cycle fetch has.

## Interface
- DEPTH, 4: FIFO entries (power of two, ≥2)
- MEM_SIZE, 1024: instruction memory size in bytes; any byte at address ≥ MEM_SIZE is an address error
- RESET_PC, 0: fetch PC after reset
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- imem_addr  out  64  current fetch PC
- imem_rdata  in  80  bytes PC..PC+9, little-endian (byte i = bits 8i+7:8i), combinational from imem_addr
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  64  restart PC
- out_valid  out  1  FIFO head valid
- out_ready  in  1  decode accepts head
- out_icode, out_ifun, out_rA, out_rB  out  4 each  head fields
- out_valC, out_valP, out_pc  out  64 each  head constant, next sequential PC, instruction PC
- out_stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS
- q_count  out  log2(DEPTH)+1  FIFO occupancy

## Operation
- Decode from imem_rdata: icode = byte0[7:4], ifun = byte0[3:0].
- Lengths: halt/nop/ret (0,1,9) = 1; cmov/OPq/pushq/popq (2,6,A,B) = 2; jXX/call (7,8) = 9; irmovq/rmmovq/mrmovq (3,4,5) = 10.
- Register byte (2-byte and 10-byte forms): rA = byte1[7:4], rB = byte1[3:0]. Otherwise rA = rB = 0xF.
- valC = bytes 2..9 for the 10-byte forms, bytes 1..8 for jXX/call, else 0.
- valP = PC + length, modulo 2^64.
- Status, in priority order:
  - ADR if PC ≥ MEM_SIZE or PC+length > MEM_SIZE.
  - INS if icode > 0xB, or ifun ≠ 0 for icode ∉ {2,6,7}, or ifun > 6 for icode 2/7, or ifun > 3 for icode 6.
  - HLT if icode 0.
  - Else AOK.
  - INS takes length 1 for the valP calculation. ADR entries still carry the decoded fields.
- Next-PC prediction: jXX and call go to valC (predicted taken); all others go to valP.
- States:
  - RUN: push one entry per cycle when q_count < DEPTH, then advance the PC.
  - WAIT_RET: entered after pushing ret. No fetch; PC holds the ret address.
  - STOPPED: entered after pushing an entry with stat ≠ AOK. No fetch; PC holds the faulting instruction's address.
  - Leaving WAIT_RET or STOPPED requires a redirect or reset.
- FIFO push requires q_count < DEPTH as sampled that cycle; a same-cycle pop does not free a slot (no bypass). Pop occurs when out_valid && out_ready.
- redirect_valid overrides everything at the edge: FIFO cleared (q_count 0), PC ← redirect_pc, state ← RUN, no push that cycle. A pop in the same cycle is discarded with the flush.
- While q_count = 0, all out_* fields are 0.

## Timing
- Reset values: PC = RESET_PC, state RUN, q_count 0, out_valid 0, all out_* fields 0.
- imem_addr equals the PC register, with no delay.
- Latency: an instruction fetched in cycle N is visible at the FIFO head in cycle N+1 if the FIFO was empty.
- Throughput is one instruction per cycle with out_ready held high.
- After a redirect edge: out_valid = 0 for exactly one cycle, then the redirect_pc entry appears.
- Reset asserted mid-stream clears the FIFO and state immediately (asynchronous). The first fetch is at RESET_PC on the first edge after deassertion.
- Full FIFO with out_ready = 0: PC and state hold, imem_addr constant, no entry lost or duplicated.
- The 64-bit PC wraps modulo 2^64; this is reported as ADR by the bounds check.

## Test plan
- Sequential program, mem = 30 F2 0A 00 00 00 00 00 00 00 | 10 | 00, out_ready = 1 -> three entries:
  - pc 0: icode 3, rA F, rB 2, valC 10, valP 10, stat 1.
  - pc 10: nop, valP 11.
  - pc 11: stat 2.
  - Then out_valid stays 0 and imem_addr stays 11.
- Backpressure, 8 nops, out_ready = 0 -> q_count reaches 4 after 4 edges and imem_addr holds at 4. Releasing out_ready drains pc 0..7 in order with no gaps beyond one cycle.
- Jump prediction, mem[0] = 70 20 00 00 00 00 00 00 00 -> entry pc 0 with valC 0x20, valP 9; next entry pc 0x20.
- ret then redirect, mem[0] = 90 -> one entry with stat 1, then no fetch for 5 cycles. A redirect pulse with redirect_pc = 0x40 gives the next entry pc 0x40, two edges after the pulse.
- Flush while full: q_count 4, then redirect to 0x80 -> next cycle q_count 0 and out_valid 0; the following cycle the head is pc 0x80.
- Errors, MEM_SIZE = 16:
  - irmovq at pc 8 -> stat 3.
  - byte C0 -> stat 4.
  - 64 12 (OPq ifun 4) -> stat 4.
  - Each case stops fetch until a redirect.
